// File: rtl/eb_pack_if.sv
// Stream bundle for eb_pack: narrow t_0 beat stream in, wide i_0 packed word out.
// Optional last/keep sideband exists only when EB_PACK_LAST_EN is defined.
interface eb_pack_if #(
  parameter int T_0_WIDTH = 8,
  parameter int RATIO     = 4
);
  // Handshake: a transfer happens on the rising edge where valid && ready on that
  // side; ready never depends on valid of the same side.
  logic [T_0_WIDTH-1:0]       t_0_data;
  logic                       t_0_valid;
  logic                       t_0_ready;
  logic [T_0_WIDTH*RATIO-1:0] i_0_data;
  logic                       i_0_valid;
  logic                       i_0_ready;
`ifdef EB_PACK_LAST_EN
  logic                       t_0_last;
  logic                       i_0_last;
  logic [RATIO-1:0]           i_0_keep;
`endif

  modport master (
    output t_0_data, t_0_valid, i_0_ready,
`ifdef EB_PACK_LAST_EN
    output t_0_last,
    input  i_0_last, i_0_keep,
`endif
    input  t_0_ready, i_0_data, i_0_valid
  );

  modport slave (
    input  t_0_data, t_0_valid, i_0_ready,
`ifdef EB_PACK_LAST_EN
    input  t_0_last,
    output i_0_last, i_0_keep,
`endif
    output t_0_ready, i_0_data, i_0_valid
  );
endinterface

// File: rtl/eb_pack.sv
// Packs RATIO narrow beats into one registered wide word, lane 0 at the LSBs.
// Define EB_PACK_LAST_EN to add t_0_last / i_0_last / i_0_keep for short words.
module eb_pack #(
  parameter int T_0_WIDTH = 8,
  parameter int RATIO     = 4,
  parameter int I_0_WIDTH = T_0_WIDTH * RATIO
) (
  input  logic     clk,
  input  logic     reset,
  eb_pack_if.slave bus
);
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW = T_0_WIDTH * (RATIO - 1);

  if (I_0_WIDTH != T_0_WIDTH * RATIO || RATIO < 2) begin : g_bad_cfg
    $error("eb_pack: need RATIO >= 2 and I_0_WIDTH == T_0_WIDTH*RATIO");
  end

  logic [CW-1:0]        cnt;
  logic [AW-1:0]        acc;
  logic [I_0_WIDTH-1:0] word;
  logic                 closing;
  logic                 accept;
`ifdef EB_PACK_LAST_EN
  logic [RATIO-1:0]     keep;

  assign closing = (cnt == CW'(RATIO - 1)) || bus.t_0_last;
`else
  assign closing = (cnt == CW'(RATIO - 1));
`endif

  // Only a closing beat can be blocked, and only while the output word is stuck.
  assign bus.t_0_ready = !(closing && bus.i_0_valid && !bus.i_0_ready);
  assign accept        = bus.t_0_valid && bus.t_0_ready;

  // Word as it would be emitted if the current beat closes it; lanes above cnt are zero.
  always_comb begin
    word = '0;
`ifdef EB_PACK_LAST_EN
    keep = '0;
`endif
    for (int j = 0; j < RATIO - 1; j++) begin
      if (j == int'(cnt)) begin
        word[j*T_0_WIDTH +: T_0_WIDTH] = bus.t_0_data;
`ifdef EB_PACK_LAST_EN
        keep[j] = 1'b1;
`endif
      end else if (j < int'(cnt)) begin
        word[j*T_0_WIDTH +: T_0_WIDTH] = acc[j*T_0_WIDTH +: T_0_WIDTH];
`ifdef EB_PACK_LAST_EN
        keep[j] = 1'b1;
`endif
      end
    end
    if (cnt == CW'(RATIO - 1)) begin
      word[(RATIO-1)*T_0_WIDTH +: T_0_WIDTH] = bus.t_0_data;
`ifdef EB_PACK_LAST_EN
      keep[RATIO-1] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      acc           <= '0;
      bus.i_0_data  <= '0;
      bus.i_0_valid <= 1'b0;
`ifdef EB_PACK_LAST_EN
      bus.i_0_last  <= 1'b0;
      bus.i_0_keep  <= '0;
`endif
    end else begin
      if (bus.i_0_ready) begin
        bus.i_0_valid <= 1'b0;
      end
      if (accept) begin
        if (closing) begin
          // Overrides the drain above so back-to-back words have no gap.
          bus.i_0_data  <= word;
          bus.i_0_valid <= 1'b1;
          cnt           <= '0;
          acc           <= '0;
`ifdef EB_PACK_LAST_EN
          bus.i_0_last  <= bus.t_0_last;
          bus.i_0_keep  <= keep;
`endif
        end else begin
          for (int k = 0; k < RATIO - 1; k++) begin
            if (cnt == CW'(k)) begin
              acc[k*T_0_WIDTH +: T_0_WIDTH] <= bus.t_0_data;
            end
          end
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
